// File: rtl/left_shift_arbiter_if.sv
// left_shift_arbiter_if: requester and consumer valid/ready bundle for left_shift_arbiter.
interface left_shift_arbiter_if #(
    parameter int width = 8,
    parameter int reqCount = 4
);
    localparam int sw = $clog2(width);
    localparam int iw = $clog2(reqCount);
    logic [reqCount-1:0] reqValid;
    logic [reqCount-1:0] reqReady;
    logic [reqCount*width-1:0] reqBits;
    logic [reqCount*sw-1:0] reqShift;
    logic outValid;
    logic outReady;
    logic [width-1:0] outBits;
    logic [iw-1:0] outId;
    modport master (
        output reqValid, reqBits, reqShift, outReady,
        input reqReady, outValid, outBits, outId
    );
    modport slave (
        input reqValid, reqBits, reqShift, outReady,
        output reqReady, outValid, outBits, outId
    );
endinterface

// File: rtl/left_shift_arbiter.sv
// left_shift_arbiter: round-robin share of one left shifter among requesters, one registered result slot.
module left_shift_arbiter #(
    parameter int width = 8,
    parameter int reqCount = 4
) (
    input logic clk,
    input logic rst_n,
    left_shift_arbiter_if.slave bus
);
    localparam int sw = $clog2(width);
    localparam int iw = $clog2(reqCount);
    logic [iw-1:0] ptr;
    logic [iw-1:0] grant;
    logic [iw-1:0] idx;
    logic found;
    logic free;
    logic accept;
    logic [width-1:0] operand;
    logic [sw-1:0] shamt;
    logic [width-1:0] shifted;
    assign free = rst_n && (!bus.outValid || bus.outReady);
    // descending scan so the requester closest above ptr wins
    always_comb begin
        grant = ptr;
        found = 1'b0;
        idx = '0;
        for (int k = reqCount - 1; k >= 0; k--) begin
            idx = iw'((int'(ptr) + k) % reqCount);
            if (bus.reqValid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end
    assign accept = free && found;
    assign bus.reqReady = accept ? reqCount'(1) << grant : '0;
    assign operand = bus.reqBits[grant*width +: width];
    assign shamt = bus.reqShift[grant*sw +: sw];
    assign shifted = operand << shamt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outValid <= 1'b0;
            bus.outBits <= '0;
            bus.outId <= '0;
            ptr <= '0;
        end else if (accept) begin
            bus.outValid <= 1'b1;
            bus.outBits <= shifted;
            bus.outId <= grant;
            ptr <= (grant == iw'(reqCount - 1)) ? '0 : grant + 1'b1;
        end else if (bus.outReady) begin
            bus.outValid <= 1'b0;
        end
    end
endmodule

// File: doc/left_shift_arbiter.md
# left_shift_arbiter

Round-robin arbiter that shares a single combinational left shifter among `reqCount` requesters and registers the result into one output slot. It sits between several shift clients and a downstream consumer, using valid/ready handshakes on both sides. It sustains one shift per cycle when the consumer keeps `outReady` high. Each result is tagged with the requester index so the consumer can route it back.

## Interface
- `width`, 8, bit width of every input operand and of the result (≥2)
- `reqCount`, 4, number of requesters (≥2)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `reqValid`  in  reqCount  per-requester request valid
- `reqReady`  out  reqCount  per-requester accept strobe, at most one bit high
- `reqBits`  in  reqCount·width  operands; requester i occupies bits [i·width +: width]
- `reqShift`  in  reqCount·clog2(width)  shift amounts; requester i occupies [i·clog2(width) +: clog2(width)]
- `outValid`  out  1  output slot holds a result
- `outReady`  in  1  consumer accepts the result
- `outBits`  out  width  registered result of operand << shift
- `outId`  out  clog2(reqCount)  index of the requester that produced `outBits`

## Operation
- Shared datapath: the block uses one shifter instance, whose operand and shift amount come from a mux driven by the current grant.
- Result: `outBits = (operand << shift)` truncated to `width`. Bits shifted out are lost and zeros fill from the LSB. For non-power-of-2 `width`, any shift ≥ `width` yields 0.
- Slot free condition: `free = !outValid || outReady`.
- Grant: when `free`, grant the first requester with `reqValid` set, searching upward from pointer `ptr` and wrapping modulo `reqCount`.
  - `reqReady[grant]=1`; all other `reqReady` bits are 0.
  - If `free` is low or no request is valid, `reqReady` is all zeros.
- `reqReady` is combinational from `reqValid`, `outValid`, `outReady` and `ptr`. Requesters must not make `reqValid` depend on `reqReady`.
- Requester rule: once `reqValid[i]` is asserted, hold it together with operand and shift stable until `reqReady[i]` is seen high. Behaviour is undefined otherwise.
- On accept (`reqValid[g] && reqReady[g]`) at the clock edge:
  - `outBits ← shifted operand g`, `outId ← g`, `outValid ← 1`
  - `ptr ← (g+1) mod reqCount`
- On drain without accept (`outValid && outReady`, no valid request): `outValid ← 0`. `outBits` and `outId` hold their values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and `outValid` stays 1, giving zero bubble.
- `outValid && !outReady`: the slot holds, `reqReady` stays all zero, and `ptr` is unchanged.
- `ptr` changes only on an accept.
- Fairness: a continuously valid requester waits at most `reqCount−1` accepts by other requesters.

## Timing
- Reset (asynchronous assert, released synchronously by the environment): `outValid=0`, `outBits=0`, `outId=0`, `ptr=0`.
  - Consequence: `reqReady` is all zeros while `rst_n=0`.
  - Reset mid-operation discards the held result and restores requester 0 as the first searched.
- Latency: accept at edge N → `outValid=1` with the result visible from edge N through the next cycle (1 cycle).
- Throughput: 1 result per cycle with `outReady` held high.
- Backpressure: the result stays stable while `outValid && !outReady`, for any number of cycles.
- `reqReady` may toggle within a cycle as inputs settle. Only its value at the rising edge counts.

## Test plan
- Reset behaviour: with all `reqValid=0`, apply reset → `outValid=0`, `outBits=0`, `outId=0`.
  - Then single request: requester 2 sends `0x35`, shift 3, `outReady=1` → `reqReady=4'b0100` in that cycle; next cycle `outBits=0xA8`, `outId=2`, `outValid=1`.
- Round robin: all four requesters valid continuously, `outReady=1` → grant order 0,1,2,3,0,… with `outId` tracking it every cycle and no bubbles.
- Backpressure: result held with `outReady=0` for 5 cycles → `outBits`/`outId` stable and `reqReady` all zeros.
  - Then raise `outReady` while requester 1 is valid → same-cycle handoff; the next cycle shows requester 1's result with `outValid` never dropping.
- Truncation and edge shifts:
  - `0xFF` shift 7 → `0x80`
  - shift 0 → operand unchanged
  - `width=6` instance, shift 6 or 7 → `0`
- Reset mid-operation: assert `rst_n=0` while `outValid=1` and the pointer sits at 3 → `outValid` drops asynchronously.
  - After release with all requesters valid, the first grant goes to requester 0.
- Fairness randomized: random `reqValid` and `outReady` for 10k cycles.
  - Scoreboard checks: every accepted request produces exactly one correct, correctly tagged result.
  - No requester waits more than 3 other accepts while valid.
  - `reqReady` is always one-hot or zero.
